// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every datapath enable, mux select and aluop.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
        BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   pc_write, branch;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // PC+imm<<2 is precomputed here so BEQEX can use ALU out
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (state_q == ADDIEX) state_d = ADDIWB;
                else if (op == OP_SW)  state_d = MEMWR;
                else                   state_d = MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_d   = RTYPEWB;
            end
            RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIWB:  reg_write = 1'b1;
            JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts in flight: suppress every strobe and select this cycle
        if (!rst_n) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            aluop      = 2'b00;
            pc_src     = 2'b00;
            illegal    = 1'b0;
        end
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = rst_n ? state_q : 4'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each cycle pushes the expected
// output vector derived from the state table and compares it at the falling edge.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, aluop, pc_src;
    logic [3:0] state;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    int checks = 0;
    int failures = 0;
    logic [18:0] sb_q[$];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    wire [18:0] act = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, aluop, pc_src, illegal, state};

    // Expected outputs straight from the per-state output table
    function automatic logic [18:0] ref_out(input logic [3:0] st, input logic rs,
                                            input logic mr, input logic z, input logic ill);
        logic pe, io, mw, irw, rw, rd, m2r, sa, il, pcw, br;
        logic [1:0] sbv, ao, ps;
        pe = 0; io = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0; sa = 0; il = 0;
        pcw = 0; br = 0; sbv = 2'b00; ao = 2'b00; ps = 2'b00;
        if (rs) begin
            case (st)
                4'd0:       begin sbv = 2'b01; irw = mr; pcw = mr; end
                4'd1:       begin sbv = 2'b11; il = ill; end
                4'd2, 4'd9: begin sa = 1; sbv = 2'b10; end
                4'd3:       io = 1;
                4'd4:       begin rw = 1; m2r = 1; end
                4'd5:       begin io = 1; mw = 1; end
                4'd6:       begin sa = 1; ao = 2'b10; end
                4'd7:       begin rw = 1; rd = 1; end
                4'd8:       begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
                4'd10:      rw = 1;
                4'd11:      begin ps = 2'b10; pcw = 1; end
                default:    ;
            endcase
            pe = pcw | (br & z);
        end
        return {pe, io, mw, irw, rw, rd, m2r, sa, sbv, ao, ps, il, (rs ? st : 4'd0)};
    endfunction

    // One cycle: drive inputs, push expectation, compare at negedge, advance
    task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] o,
                        input logic [3:0] st, input logic ill, input string name);
        logic [18:0] exp;
        rst_n = r; mem_ready = mr; zero = z; op = o;
        sb_q.push_back(ref_out(st, r, mr, z, ill));
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s st%0d: got %b want %b", name, st, act, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, LW, 4'd3, 1'b0, "reset_hold");
        step(1'b1, 1'b0, 1'b0, RT, 4'd0, 1'b0, "reset_release");
    endtask

    task automatic test_lw();
        for (int s = 0; s <= 4; s++) step(1'b1, 1'b1, 1'b0, LW, 4'(s), 1'b0, "lw");
    endtask

    task automatic test_rtype();
        step(1'b1, 1'b1, 1'b0, RT, 4'd0, 1'b0, "rtype");
        step(1'b1, 1'b1, 1'b0, RT, 4'd1, 1'b0, "rtype");
        step(1'b1, 1'b1, 1'b0, RT, 4'd6, 1'b0, "rtype");
        step(1'b1, 1'b1, 1'b0, RT, 4'd7, 1'b0, "rtype");
    endtask

    task automatic test_beq(input logic z);
        step(1'b1, 1'b1, z, BEQ, 4'd0, 1'b0, "beq");
        step(1'b1, 1'b1, z, BEQ, 4'd1, 1'b0, "beq");
        step(1'b1, 1'b1, z, BEQ, 4'd8, 1'b0, z ? "beq_taken" : "beq_not_taken");
    endtask

    task automatic test_addi_j();
        step(1'b1, 1'b1, 1'b1, ADDI, 4'd0, 1'b0, "addi");
        step(1'b1, 1'b1, 1'b1, ADDI, 4'd1, 1'b0, "addi");
        step(1'b1, 1'b1, 1'b1, ADDI, 4'd9, 1'b0, "addi");
        step(1'b1, 1'b1, 1'b1, ADDI, 4'd10, 1'b0, "addi");
        step(1'b1, 1'b1, 1'b0, J, 4'd0, 1'b0, "j");
        step(1'b1, 1'b1, 1'b0, J, 4'd1, 1'b0, "j");
        step(1'b1, 1'b1, 1'b0, J, 4'd11, 1'b0, "j");
    endtask

    task automatic test_stall_sw();
        int cyc = 0;
        step(1'b1, 1'b0, 1'b0, SW, 4'd0, 1'b0, "sw_fetch_stall"); cyc++;
        step(1'b1, 1'b0, 1'b0, SW, 4'd0, 1'b0, "sw_fetch_stall"); cyc++;
        step(1'b1, 1'b1, 1'b0, SW, 4'd0, 1'b0, "sw_fetch");       cyc++;
        step(1'b1, 1'b1, 1'b0, SW, 4'd1, 1'b0, "sw");             cyc++;
        step(1'b1, 1'b1, 1'b0, SW, 4'd2, 1'b0, "sw");             cyc++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, SW, 4'd5, 1'b0, "sw_memwr_stall"); cyc++;
        end
        step(1'b1, 1'b1, 1'b0, SW, 4'd5, 1'b0, "sw_memwr");       cyc++;
        checks++;
        if (state !== 4'd0 || cyc != 9) begin
            failures++;
            $display("FAIL sw_total: state %0d cycles %0d want state 0 cycles 9", state, cyc);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b1, 1'b0, BAD, 4'd0, 1'b0, "illegal_fetch");
        step(1'b1, 1'b1, 1'b0, BAD, 4'd1, 1'b1, "illegal_decode");
        step(1'b1, 1'b0, 1'b0, BAD, 4'd0, 1'b0, "illegal_after");
    endtask

    task automatic test_abort();
        for (int s = 0; s <= 3; s++) step(1'b1, 1'b0 | (s != 3), 1'b0, LW, 4'(s), 1'b0, "abort_lw");
        step(1'b0, 1'b1, 1'b0, LW, 4'd3, 1'b0, "abort_lw_rst");
        step(1'b1, 1'b0, 1'b0, LW, 4'd0, 1'b0, "abort_lw_fetch");
        // abort a stalled store: mem_write must drop in the reset cycle
        step(1'b1, 1'b1, 1'b0, SW, 4'd0, 1'b0, "abort_sw");
        step(1'b1, 1'b1, 1'b0, SW, 4'd1, 1'b0, "abort_sw");
        step(1'b1, 1'b1, 1'b0, SW, 4'd2, 1'b0, "abort_sw");
        step(1'b1, 1'b0, 1'b0, SW, 4'd5, 1'b0, "abort_sw");
        step(1'b0, 1'b0, 1'b0, SW, 4'd5, 1'b0, "abort_sw_rst");
        step(1'b1, 1'b0, 1'b0, SW, 4'd0, 1'b0, "abort_sw_fetch");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_addi_j();
        test_stall_sw();
        test_illegal();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle MIPS datapath, directly upstream of ALU control: it decodes the instruction opcode and drives the 2-bit `aluop` consumed by ALU control, plus every datapath enable and mux select. It sequences fetch, decode, execute, memory and writeback over several cycles per instruction. It stalls on a memory ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `op`  in  6  opcode, instr[31:26], from instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes current access this cycle.
- `pc_en`  out  1  PC load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU out.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register load.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  destination: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback: 0 = ALU out, 1 = memory data.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `aluop`  out  2  00 add, 01 sub, 10 use funct; 11 never driven.
- `pc_src`  out  2  00 ALU result, 01 ALU out register, 10 jump target.
- `illegal`  out  1  one-cycle pulse on unsupported opcode.
- `state`  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- `pc_en = pc_write | (branch & zero)`; `pc_write` and `branch` are internal.
- States and transitions:
  - FETCH=0 → DECODE when `mem_ready`, else hold.
  - DECODE=1 → MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX, JEX; any other op → FETCH with `illegal`=1.
  - MEMADR=2 → MEMRD (lw) / MEMWR (sw).
  - MEMRD=3 → MEMWB when `mem_ready`, else hold.
  - MEMWR=5 → FETCH when `mem_ready`, else hold.
  - RTYPEEX=6 → RTYPEWB; ADDIEX=9 → ADDIWB.
  - MEMWB=4, RTYPEWB=7, BEQEX=8, ADDIWB=10, JEX=11 → FETCH.
  - Codes 12–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Moore outputs per state. Unlisted outputs are 0.
  - FETCH: `alu_src_b`=01, `aluop`=00; `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_b`=11, `aluop`=00 (branch target precompute).
  - MEMADR, ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00.
  - MEMRD: `iord`=1.
  - MEMWR: `iord`=1, `mem_write`=1 for every cycle in state.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - RTYPEEX: `alu_src_a`=1, `alu_src_b`=00, `aluop`=10.
  - RTYPEWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - BEQEX: `alu_src_a`=1, `alu_src_b`=00, `aluop`=01, `pc_src`=01, `branch`=1.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - JEX: `pc_src`=10, `pc_write`=1.
- `op` is sampled only in DECODE and MEMADR. The IR is stable then because `ir_write` is low outside FETCH.

## Timing
- State register updates on rising `clk`. Outputs are combinational from state plus `mem_ready`/`zero` only, with no registered outputs.
- Reset: when `rst_n`=0 at an edge, state becomes FETCH. While `rst_n`=0, every output is forced to 0, including `state`.
- Reset asserted mid-instruction aborts it. No write strobe may be asserted in the cycle `rst_n` is low.
- Cycles per instruction with `mem_ready` held 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `illegal` is high only during the DECODE cycle. The next state is FETCH, so the PC has already advanced by 4.
- beq with `zero`=0 in BEQEX: `pc_en`=0, and the PC keeps the PC+4 value loaded in FETCH.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → all outputs 0 during reset, `state`=0 on the first cycle after release, `ir_write`=`pc_en`=1 if `mem_ready`=1.
- lw (op=100011), `mem_ready`=1 → state sequence 0,1,2,3,4,0; `aluop` 00 in FETCH/DECODE/MEMADR; `reg_write`=`mem_to_reg`=1 only in state 4.
- R-type (op=000000) → states 0,1,6,7; `aluop`=10 exactly in state 6; `reg_dst`=1 with `reg_write`=1 in state 7.
- beq (op=000100) → in state 8, `aluop`=01 and `pc_src`=01; `zero`=1 gives `pc_en`=1, `zero`=0 gives `pc_en`=0.
- Stalls: `mem_ready`=0 for 2 cycles in FETCH, then 3 cycles in MEMWR during sw → stays in state 0 for 3 cycles with `ir_write`=0 until ready; `mem_write`=1 for all 4 cycles in state 5; total sw = 9 cycles.
- Illegal and abort: op=111111 → `illegal`=1 for one cycle in DECODE, then FETCH. Reset asserted in state 3 of lw → next state 0, `reg_write` never asserted.
